mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/uart_pkg.sv | 52 +++++
 rtl/sync_fifo.sv | 56 +++++
 rtl/mmio_uart_tx.sv | 158 +++++++++++++++
 tb/tb_mmio_uart_tx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM state
// encoding, register offsets, STATUS bit layout and the bus request bundle.
package uart_pkg;

  // Transmit FSM states; anything other than IDLE reports busy.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Register offsets from the block base address.
  localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

  // STATUS register layout.
  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_OVF_BIT   = 3;
  localparam int STAT_CNT_LSB   = 8;
  localparam int STAT_CNT_W     = 8;

  // Writing a 1 to this bit of STATUS clears the sticky overflow flag.
  localparam int OVF_CLR_BIT = STAT_OVF_BIT;

  // Processor data-port request as seen by this block.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
  } mmio_req_t;

  // Assemble the STATUS word; unlisted bits read as zero.
  function automatic logic [31:0] pack_status(input logic       full,
                                              input logic       empty,
                                              input logic       busy,
                                              input logic       ovf,
                                              input logic [7:0] cnt);
    logic [31:0] s;
    s                               = '0;
    s[STAT_FULL_BIT]                = full;
    s[STAT_EMPTY_BIT]               = empty;
    s[STAT_BUSY_BIT]                = busy;
    s[STAT_OVF_BIT]                 = ovf;
    s[STAT_CNT_LSB +: STAT_CNT_W]   = cnt;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO. The head entry is visible combinationally on rdata
// so a pop captures it on the same edge. A push while full is accepted only
// when a pop happens on that edge, which keeps the occupancy unchanged.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  // Storage array: written at the tail; no reset needed since count guards reads.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter. Sits beside data memory on the
// processor data port: read_data is zero for every address outside this
// block's two registers, so the system mux can simply select or OR it in.
// TXDATA (base+0) queues a byte; STATUS (base+4) reports FIFO/FSM state and
// a sticky overflow flag. tx is registered one cycle behind the FSM state,
// giving a two-edge latency from push to the start bit on an idle line.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] read_data,
  output logic        tx
);

  localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] TXDATA_ADDR = BASE_ADDR + TXDATA_OFS;
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + STATUS_OFS;
  localparam logic [15:0] BAUD_LAST   = 16'(CLKS_PER_BIT - 1);

  // Bus decode: exact address match rejects out-of-window and unaligned accesses.
  mmio_req_t req;
  logic      wr_txdata;
  logic      wr_status;
  logic      rd_status;

  assign req       = '{addr: addr, wdata: write_data, we: MemWrite, re: MemRead};
  assign wr_txdata = req.we && (req.addr == TXDATA_ADDR);
  assign wr_status = req.we && (req.addr == STATUS_ADDR);
  assign rd_status = req.re && (req.addr == STATUS_ADDR);

  // Byte queue between the bus and the serialiser.
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_txdata),
    .wdata (req.wdata[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Serialiser state.
  tx_state_e   state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        ovf;
  logic        ovf_set;
  logic        ovf_clr;
  logic        baud_done;

  // The FSM takes the head byte on any IDLE edge with data waiting.
  assign fifo_pop  = (state == IDLE) && !fifo_empty;
  assign baud_done = (baud_cnt == BAUD_LAST);

  // A push lost to a full FIFO (no same-edge pop) flags overflow.
  assign ovf_set = wr_txdata && fifo_full && !fifo_pop;
  assign ovf_clr = wr_status && req.wdata[OVF_CLR_BIT];

  // Sticky overflow flag; a set on the same edge as a clear takes priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         ovf <= 1'b0;
    else if (ovf_set) ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  // Frame FSM: start bit, 8 data bits LSB first, stop bit; tx follows state by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!fifo_empty) begin
            shreg    <= fifo_head;
            baud_cnt <= '0;
            state    <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (baud_done) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          tx <= shreg[0];
          if (baud_done) begin
            baud_cnt <= '0;
            shreg    <= {1'b0, shreg[7:1]};
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Load path: STATUS on a matching read, zero otherwise (TXDATA reads as zero too).
  logic [31:0] status;
  assign status    = pack_status(fifo_full, fifo_empty, state != IDLE, ovf, 8'(fifo_count));
  assign read_data = rd_status ? status : 32'h0;

  // Only the low byte and the overflow-clear bit of store data matter here.
  logic unused_wdata;
  assign unused_wdata = ^req.wdata[31:8];

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=2. Stimulus queues
// the expected serial frames (byte plus start-bit cycle); a line monitor
// decodes every frame on tx and checks it against the queue head.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          C    = 4;
  localparam int          D    = 2;
  localparam int          FL   = 10 * C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] read_data;
  logic        tx;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .write_data (write_data),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .read_data  (read_data),
    .tx         (tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         fall;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input logic [7:0] d, input int f);
    exp_t e;
    e.data = d;
    e.fall = f;
    exp_q.push_back(e);
  endtask

  task automatic drive_wr(input logic [31:0] a, input logic [31:0] d);
    addr       = a;
    write_data = d;
    MemWrite   = 1'b1;
  endtask

  task automatic idle_bus();
    MemWrite   = 1'b0;
    MemRead    = 1'b0;
    addr       = '0;
    write_data = '0;
  endtask

  task automatic rd_status(input string name, input logic [31:0] exp);
    addr    = BASE + 32'h4;
    MemRead = 1'b1;
    #1;
    chk(name, read_data, exp);
    MemRead = 1'b0;
    addr    = '0;
  endtask

  // Line monitor: catch each falling start edge, sample the whole frame, score it.
  initial begin : monitor
    logic          prev;
    logic [FL-1:0] smp;
    logic [FL-1:0] pat;
    int            fc;
    bit            abort;
    exp_t          e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev = 1'b1;
      end else if (prev && !tx) begin
        fc     = cyc;
        smp    = '0;
        smp[0] = tx;
        abort  = 1'b0;
        for (int k = 1; k < FL; k++) begin
          @(negedge clk);
          if (!rst) begin
            abort = 1'b1;
            break;
          end
          smp[k] = tx;
        end
        if (!abort) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: got line samples %h at cycle %0d want no frame", smp, fc);
          end else begin
            e = exp_q.pop_front();
            for (int k = 0; k < FL; k++)
              pat[k] = (k < C) ? 1'b0 : (k < 9 * C) ? e.data[(k - C) / C] : 1'b1;
            total++;
            if (smp !== pat) begin
              bad++;
              $display("FAIL frame_bits: got line samples %h want %h (byte %h)", smp, pat, e.data);
            end
            if (e.fall >= 0) begin
              total++;
              if (fc != e.fall) begin
                bad++;
                $display("FAIL frame_start byte %h: got cycle %0d want %0d", e.data, fc, e.fall);
              end
            end
          end
        end
        prev = abort ? 1'b1 : tx;
      end else begin
        prev = tx;
      end
    end
  end

  initial begin : stim
    int         p;
    logic [7:0] b4[4];
    b4[0] = 8'h11; b4[1] = 8'h22; b4[2] = 8'h33; b4[3] = 8'h44;

    // Reset state, including the combinational STATUS read during reset.
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx), 32'h1);
    rd_status("reset_status", 32'h0000_0002);
    rst = 1'b1;
    @(negedge clk);
    rd_status("post_reset_status", 32'h0000_0002);

    // Single byte A5: start bit two edges after the push edge, 40-cycle frame.
    @(negedge clk);
    p = cyc + 1;
    drive_wr(BASE, 32'h0000_00A5);
    expect_frame(8'hA5, p + 2);
    @(negedge clk);
    idle_bus();
    rd_status("a5_queued_status", 32'h0000_0100);
    repeat (50) @(negedge clk);
    rd_status("a5_done_status", 32'h0000_0002);

    // Back-to-back 01, 02: second frame one idle cycle after the first stop bit.
    @(negedge clk);
    p = cyc + 1;
    drive_wr(BASE, 32'h0000_0001);
    expect_frame(8'h01, p + 2);
    @(negedge clk);
    drive_wr(BASE, 32'h0000_0002);
    expect_frame(8'h02, p + 2 + FL + 1);
    @(negedge clk);
    idle_bus();
    rd_status("pair_count_after_second", 32'h0000_0104);
    repeat (90) @(negedge clk);
    rd_status("pair_done_status", 32'h0000_0002);

    // Overflow: four pushes at reset exit, fourth dropped; then clear the flag.
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    p = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      drive_wr(BASE, {24'h0, b4[i]});
      @(negedge clk);
    end
    idle_bus();
    expect_frame(8'h11, p + 2);
    expect_frame(8'h22, p + 2 + (FL + 1));
    expect_frame(8'h33, p + 2 + 2 * (FL + 1));
    rd_status("ovf_set_status", 32'h0000_020D);
    drive_wr(BASE + 32'h4, 32'h0000_0008);
    @(negedge clk);
    idle_bus();
    rd_status("ovf_clear_status", 32'h0000_0205);
    repeat (130) @(negedge clk);
    rd_status("ovf_done_status", 32'h0000_0002);

    // Full FIFO, push lands on the pop edge as the FSM leaves IDLE.
    @(negedge clk);
    p = cyc + 1;
    drive_wr(BASE, 32'h0000_00C3);
    @(negedge clk);
    drive_wr(BASE, 32'h0000_003C);
    @(negedge clk);
    drive_wr(BASE, 32'h0000_0096);
    @(negedge clk);
    idle_bus();
    expect_frame(8'hC3, p + 2);
    expect_frame(8'h3C, p + 2 + (FL + 1));
    expect_frame(8'h96, p + 2 + 2 * (FL + 1));
    expect_frame(8'h69, p + 2 + 3 * (FL + 1));
    rd_status("full_status", 32'h0000_0205);
    while (cyc < p + 41) @(negedge clk);
    drive_wr(BASE, 32'h0000_0069);
    @(negedge clk);
    idle_bus();
    rd_status("push_on_pop_status", 32'h0000_0205);
    repeat (170) @(negedge clk);
    rd_status("push_on_pop_done", 32'h0000_0002);

    // Reset in the middle of the data bits, with a second byte still queued.
    @(negedge clk);
    p = cyc + 1;
    drive_wr(BASE, 32'h0000_005A);
    expect_frame(8'h5A, p + 2);
    @(negedge clk);
    drive_wr(BASE, 32'h0000_00B7);
    expect_frame(8'hB7, p + 2 + (FL + 1));
    @(negedge clk);
    idle_bus();
    while (cyc < p + 15) @(negedge clk);
    chk("mid_data_tx_low", 32'(tx), 32'h0);
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("reset_tx_async_high", 32'(tx), 32'h1);
    rd_status("reset_mid_frame_status", 32'h0000_0002);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    chk("after_abort_tx_idle", 32'(tx), 32'h1);
    rd_status("after_abort_status", 32'h0000_0002);

    // Out-of-window and unaligned accesses.
    @(negedge clk);
    MemRead = 1'b1;
    addr = BASE + 32'h8;
    #1 chk("rd_base_plus_8", read_data, 32'h0);
    addr = BASE + 32'h1;
    #1 chk("rd_base_plus_1", read_data, 32'h0);
    addr = BASE;
    #1 chk("rd_txdata", read_data, 32'h0);
    MemRead = 1'b0;
    addr = BASE + 32'h4;
    #1 chk("status_without_memread", read_data, 32'h0);
    @(negedge clk);
    drive_wr(BASE + 32'h8, 32'h0000_0077);
    @(negedge clk);
    drive_wr(BASE + 32'h1, 32'h0000_0078);
    @(negedge clk);
    idle_bus();
    rd_status("ignored_writes_status", 32'h0000_0002);
    repeat (10) @(negedge clk);
    chk("ignored_writes_tx", 32'(tx), 32'h1);

    // Every queued frame must have been seen.
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d frames outstanding want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
